ex_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the YADAN execute stage, implementing all eight RV32M/RV64M operations with a start/done handshake. The unit captures operands on `start_i`, iterates `STEP` bits per cycle, applies RISC-V corner-case semantics (divide-by-zero, signed overflow) and returns the final `XLEN`-bit result selected by opcode. The `ex` stage can therefore forward `result_o` without slicing it. `kill_i` aborts an operation in flight when an interrupt or flush is taken.

---
 rtl/ex_muldiv_pkg.sv | 41 ++++
 rtl/ex_muldiv_step.sv | 48 ++++
 rtl/ex_muldiv.sv | 188 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ============================================================================
// Module   : ex_muldiv_pkg
// Brief    : Shared encodings and helpers for the YADAN multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_muldiv_pkg;

  // Operation codes presented on op_i
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // Controller states
  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_CALC  = 2'd1;
  localparam logic [1:0] MD_FIXUP = 2'd2;
  localparam logic [1:0] MD_DONE  = 2'd3;

  // Default number of bits retired per iteration
  localparam int MD_STEP = 1;

  // rs1 is interpreted as two's complement for MULH, MULHSU, DIV and REM
  function automatic logic op_signed_rs1(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as two's complement for MULH, DIV and REM
  function automatic logic op_signed_rs2(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_step.sv
// ============================================================================
// Module   : ex_muldiv_step
// Brief    : One-bit iteration slice: shift-add for multiply, restoring
//            shift-subtract for divide. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_step
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            div_i,  // 1: divide iteration, 0: multiply iteration
  input  logic [XLEN-1:0] hi_i,   // product high half / partial remainder
  input  logic [XLEN-1:0] lo_i,   // multiplier bits / dividend-then-quotient bits
  input  logic [XLEN-1:0] b_i,    // multiplicand / divisor magnitude
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // Multiply consumes lo[0] and shifts the accumulator right; divide shifts the
  // next dividend bit into the remainder and keeps the subtraction only if it
  // did not borrow, shifting the quotient bit into lo.
  always_comb begin
    w_sum   = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : {XLEN{1'b0}})};
    w_shift = {hi_i, lo_i[XLEN-1]};
    w_diff  = w_shift - {1'b0, b_i};
    hi_o    = w_sum[XLEN:1];
    lo_o    = {w_sum[0], lo_i[XLEN-1:1]};
    if (div_i) begin
      if (!w_diff[XLEN]) begin
        hi_o = w_diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = w_shift[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative RV32M/RV64M multiply/divide unit with start/done
//            handshake, STEP bits per cycle, RISC-V corner-case semantics and
//            kill support.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = MD_STEP
) (
  input  logic            clk,
  input  logic            rst,        // asynchronous, active low
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int               N        = XLEN / STEP;
  localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_neg1;
  logic             r_neg2;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;

  logic             w_accept;
  logic             w_sgn1;
  logic             w_sgn2;
  logic [XLEN-1:0]  w_mag1;
  logic [XLEN-1:0]  w_mag2;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_res;

  logic [XLEN-1:0]   w_hi [0:STEP];
  logic [XLEN-1:0]   w_lo [0:STEP];
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  // Start acceptance, operand sign/magnitude extraction and corner-case detection
  always_comb begin
    w_accept  = ((r_state == MD_IDLE) || (r_state == MD_DONE)) && start_i && !kill_i;
    w_sgn1    = op_signed_rs1(op_i) && operand1_i[XLEN-1];
    w_sgn2    = op_signed_rs2(op_i) && operand2_i[XLEN-1];
    w_mag1    = w_sgn1 ? (~operand1_i + 1'b1) : operand1_i;
    w_mag2    = w_sgn2 ? (~operand2_i + 1'b1) : operand2_i;
    w_div0    = op_i[2] && (operand2_i == {XLEN{1'b0}});
    // Only the signed divide/remainder ops (op[0] clear) can overflow
    w_ovf     = op_i[2] && !op_i[0]
                && (operand1_i == {1'b1, {(XLEN-1){1'b0}}})
                && (operand2_i == {XLEN{1'b1}});
    w_special = w_div0 || w_ovf;
    // op[1] separates remainder from quotient results
    if (w_div0) begin
      w_special_res = op_i[1] ? operand1_i : {XLEN{1'b1}};
    end else begin
      w_special_res = op_i[1] ? {XLEN{1'b0}} : operand1_i;
    end
  end

  // Chain of STEP iteration slices evaluated each CALC cycle
  assign w_hi[0] = r_hi;
  assign w_lo[0] = r_lo;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_step
    ex_muldiv_step #(.XLEN(XLEN)) u_step (
      .div_i (r_op[2]),
      .hi_i  (w_hi[gi]),
      .lo_i  (w_lo[gi]),
      .b_i   (r_b),
      .hi_o  (w_hi[gi+1]),
      .lo_o  (w_lo[gi+1])
    );
  end

  // Sign correction of the magnitude results and final result select
  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg1 ^ r_neg2) begin
      w_prod = ~w_prod + 1'b1;
    end
    w_quot = (r_neg1 ^ r_neg2) ? (~r_lo + 1'b1) : r_lo;
    w_rem  = r_neg1 ? (~r_hi + 1'b1) : r_hi;
    if (r_op[2]) begin
      w_fix_res = r_op[1] ? w_rem : w_quot;
    end else if (r_op == MD_MUL) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; kill wins over everything, including a same-cycle start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE, MD_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? MD_DONE : MD_CALC;
        end else begin
          w_state_nxt = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (kill_i) begin
          w_state_nxt = MD_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = MD_FIXUP;
        end
      end
      MD_FIXUP: begin
        w_state_nxt = kill_i ? MD_IDLE : MD_DONE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // State and registered handshake outputs, derived from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MD_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy_o  <= (w_state_nxt == MD_CALC) || (w_state_nxt == MD_FIXUP);
      done_o  <= (w_state_nxt == MD_DONE);
    end
  end

  // Result register: corner cases at the accepting edge, normal ops in FIXUP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_o <= {XLEN{1'b0}};
    end else if (w_accept && w_special) begin
      result_o <= w_special_res;
    end else if ((r_state == MD_FIXUP) && !kill_i) begin
      result_o <= w_fix_res;
    end
  end

  // Operand capture on accept, iteration update while calculating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_op   <= MD_MUL;
      r_neg1 <= 1'b0;
      r_neg2 <= 1'b0;
      r_hi   <= {XLEN{1'b0}};
      r_lo   <= {XLEN{1'b0}};
      r_b    <= {XLEN{1'b0}};
    end else if (w_accept) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_op   <= op_i;
      r_neg1 <= w_sgn1;
      r_neg2 <= w_sgn2;
      r_hi   <= {XLEN{1'b0}};
      r_lo   <= w_mag1;
      r_b    <= w_mag2;
    end else if (r_state == MD_CALC) begin
      r_cnt  <= r_cnt + 1'b1;
      r_hi   <= w_hi[STEP];
      r_lo   <= w_lo[STEP];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Self-checking bench for ex_muldiv; one instance at XLEN=32/STEP=1
//            and one at XLEN=64/STEP=4, checked against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [2];
  logic [2:0]  op_v    [2];
  logic [63:0] a_v     [2];
  logic [63:0] b_v     [2];
  logic        kill_v  [2];

  logic        busy32, done32, busy64, done64;
  logic [31:0] res32;
  logic [63:0] res64;

  logic        sel;
  logic        cur_busy, cur_done;
  logic [63:0] cur_res;
  logic [63:0] last_res [2];

  int total = 0;
  int bad   = 0;

  assign cur_busy = sel ? busy64 : busy32;
  assign cur_done = sel ? done64 : done32;
  assign cur_res  = sel ? res64 : {32'h0, res32};

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .STEP(1)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .op_i(op_v[0]),
    .operand1_i(a_v[0][31:0]), .operand2_i(b_v[0][31:0]), .kill_i(kill_v[0]),
    .busy_o(busy32), .done_o(done32), .result_o(res32)
  );

  ex_muldiv #(.XLEN(64), .STEP(4)) u_dut64 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .op_i(op_v[1]),
    .operand1_i(a_v[1]), .operand2_i(b_v[1]), .kill_i(kill_v[1]),
    .busy_o(busy64), .done_o(done64), .result_o(res64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics using wide integer arithmetic
  function automatic logic [63:0] ref_model(input logic s, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
    int                 xl;
    logic [63:0]        m, r, amin;
    logic signed [127:0] sa, sb, ua, ub, p;
    logic               zero, ovf;
    xl   = s ? 64 : 32;
    m    = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    amin = s ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    ua   = {64'h0, a & m};
    ub   = {64'h0, b & m};
    sa   = s ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
    sb   = s ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
    zero = ((b & m) == 64'h0);
    ovf  = ((a & m) == amin) && ((b & m) == m);
    r    = 64'h0;
    case (op)
      3'd0: begin p = ua * ub; r = p[63:0]; end
      3'd1: begin p = sa * sb; p = p >> xl; r = p[63:0]; end
      3'd2: begin p = sa * ub; p = p >> xl; r = p[63:0]; end
      3'd3: begin p = ua * ub; p = p >> xl; r = p[63:0]; end
      3'd4: begin
        if (zero) r = '1;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[63:0]; end
      end
      3'd5: begin
        if (zero) r = '1;
        else begin p = ua / ub; r = p[63:0]; end
      end
      3'd6: begin
        if (zero) r = a;
        else if (ovf) r = 64'h0;
        else begin p = sa % sb; r = p[63:0]; end
      end
      default: begin
        if (zero) r = a;
        else begin p = ua % ub; r = p[63:0]; end
      end
    endcase
    return r & m;
  endfunction

  function automatic logic is_special(input logic s, input logic [2:0] op,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, amin;
    m    = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    amin = s ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (op < 3'd4) return 1'b0;
    if ((b & m) == 64'h0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && ((a & m) == amin) && ((b & m) == m);
  endfunction

  // Present an op for one edge, then scramble the inputs
  task automatic launch(input logic s, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b);
    sel        = s;
    start_v[s] = 1'b1;
    op_v[s]    = op;
    a_v[s]     = a;
    b_v[s]     = b;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    op_v[s]    = 3'($urandom);
    a_v[s]     = {$urandom, $urandom};
    b_v[s]     = {$urandom, $urandom};
  endtask

  // Count edges after the accepting edge until done, and busy cycles on the way
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!cur_done && lat < 300) begin
      if (cur_busy) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic s, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input string tag,
                        input logic at_negedge);
    int lat, bc, n;
    n = s ? 16 : 32;
    if (at_negedge) @(negedge clk);
    launch(s, op, a, b);
    wait_done(lat, bc);
    check({tag, ".res"}, cur_res, exp);
    check({tag, ".lat"}, 64'(lat), is_special(s, op, a, b) ? 64'd0 : 64'(n + 1));
    check({tag, ".busy"}, 64'(bc), is_special(s, op, a, b) ? 64'd0 : 64'(n + 1));
    check({tag, ".overlap"}, {63'h0, cur_busy}, 64'h0);
    last_res[s] = exp;
  endtask

  initial begin
    int dcount;
    logic [2:0]  op;
    logic [63:0] a, b, m;

    rst = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; op_v[i] = 3'd0; a_v[i] = 64'h0; b_v[i] = 64'h0;
      kill_v[i] = 1'b0; last_res[i] = 64'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy32", {63'h0, busy32}, 64'h0);
    check("rst.done32", {63'h0, done32}, 64'h0);
    check("rst.res32", {32'h0, res32}, 64'h0);
    check("rst.busy64", {63'h0, busy64}, 64'h0);
    check("rst.done64", {63'h0, done64}, 64'h0);
    check("rst.res64", res64, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases at XLEN=32, STEP=1
    run_op(0, 3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, "mul", 1);
    run_op(0, 3'd1, 64'h80000000, 64'h80000000, 64'h40000000, "mulh", 1);
    run_op(0, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, "mulhsu", 1);
    run_op(0, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, "mulhu", 1);
    run_op(0, 3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, "div", 1);
    run_op(0, 3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, "rem", 1);
    run_op(0, 3'd5, 64'd100,      64'd7,        64'd14,       "divu", 1);
    run_op(0, 3'd7, 64'd100,      64'd7,        64'd2,        "remu", 1);
    run_op(0, 3'd4, 64'd5,        64'd0,        64'hFFFFFFFF, "div0", 1);
    run_op(0, 3'd7, 64'd5,        64'd0,        64'd5,        "remu0", 1);
    run_op(0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, "divovf", 1);
    run_op(0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        "removf", 1);

    // Back-to-back: second start issued in the DONE cycle of the first
    run_op(0, 3'd5, 64'd1000,     64'd9,        64'd111,      "b2b1", 1);
    run_op(0, 3'd0, 64'd12345,    64'd678,      64'd8369910,  "b2b2", 0);
    run_op(0, 3'd7, 64'd9,        64'd0,        64'd9,        "b2b3", 0);
    run_op(0, 3'd3, 64'h10000,    64'h10000,    64'h1,        "b2b4", 0);

    // Kill at cycle 10 of a DIV: no done, busy drops, result held
    @(negedge clk);
    launch(0, 3'd4, 64'h12345678, 64'd3);
    repeat (9) @(posedge clk);
    #1;
    kill_v[0] = 1'b1;
    @(posedge clk);
    #1;
    kill_v[0] = 1'b0;
    check("kill.busy", {63'h0, busy32}, 64'h0);
    check("kill.done", {63'h0, done32}, 64'h0);
    check("kill.res", {32'h0, res32}, last_res[0]);
    dcount = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32 || busy32) dcount++;
    end
    check("kill.quiet", 64'(dcount), 64'h0);

    // Kill in IDLE cancels a same-cycle start (corner-case op would finish at once)
    @(negedge clk);
    kill_v[0] = 1'b1; start_v[0] = 1'b1; op_v[0] = 3'd4; a_v[0] = 64'd5; b_v[0] = 64'd0;
    @(posedge clk);
    #1;
    kill_v[0] = 1'b0; start_v[0] = 1'b0;
    check("killstart.done", {63'h0, done32}, 64'h0);
    check("killstart.busy", {63'h0, busy32}, 64'h0);
    check("killstart.res", {32'h0, res32}, last_res[0]);

    // Randomized regressions on both instances
    for (int s = 0; s < 2; s++) begin
      m = (s == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      for (int i = 0; i < 40; i++) begin
        op = 3'($urandom_range(0, 7));
        a  = {$urandom, $urandom} & m;
        b  = {$urandom, $urandom} & m;
        case ($urandom_range(0, 9))
          0: b = 64'h0;
          1: begin a = (s == 1) ? 64'h8000_0000_0000_0000 : 64'h8000_0000; b = m; end
          2: begin a = 64'($urandom_range(0, 300)); b = 64'($urandom_range(1, 20)); end
          3: b = (m ^ 64'($urandom_range(0, 3)));
          default: ;
        endcase
        run_op(s[0], op, a, b, ref_model(s[0], op, a, b), (s == 1) ? "rnd64" : "rnd32",
               ($urandom_range(0, 3) != 0));
      end
    end

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    launch(1, 3'd1, 64'hDEAD_BEEF_1234_5678, 64'h8765_4321_0FED_CBA9);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst.busy64", {63'h0, busy64}, 64'h0);
    check("arst.done64", {63'h0, done64}, 64'h0);
    check("arst.res64", res64, 64'h0);
    check("arst.res32", {32'h0, res32}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    last_res[0] = 64'h0;
    last_res[1] = 64'h0;
    run_op(1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ref_model(1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3),
           "postrst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
